// File: rtl/pipe_uncorrect.sv
// pipe_uncorrect: undoes an upstream per-transaction correction factor on two
// data channels. A sample is divided by cf with a shared restoring divider that
// retires one quotient bit per cycle. Channel 0 is handled in DIV0 and
// channel 1 in DIV1. The result is then held in DONE until it is taken.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_valid / o_ready   upstream handshake (accept = i_valid && o_ready)
//   i_cf                correction factor (0..2^CFW-1)
//   i_data0 / i_data1   corrected channel samples
//   o_valid / i_ready   downstream handshake
//   o_data0 / o_data1   recovered samples
//   o_rem_err           a divided channel left a nonzero remainder
//   o_cf_err            cf==0 was seen on a non-special sample
module pipe_uncorrect #(
  parameter int DW  = 16,
  parameter int CFW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [CFW-1:0] i_cf,
  input  logic [DW-1:0]  i_data0,
  input  logic [DW-1:0]  i_data1,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [DW-1:0]  o_data0,
  output logic [DW-1:0]  o_data1,
  output logic           o_rem_err,
  output logic           o_cf_err
);

  localparam int RW = DW + CFW;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, DIV0, DIV1, DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   d0_q, d1_q, dq_q, dq_d, cur, res;
  logic [CFW-1:0]  cf_q;
  logic [RW-1:0]   rem_q, rem_d;
  logic [RW:0]     trial;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   data0_q, data1_q;
  logic            valid_q, rem_err_q, cf_err_q;
  logic            accept, in_div, special, bypass, ch_done, qbit;
  logic            res_rem_err, res_cf_err;

  assign accept = i_valid && o_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)            state_d = DIV0;
      DIV0: if (ch_done)           state_d = DIV1;
      DIV1: if (ch_done)           state_d = DONE;
      DONE: if (valid_q && i_ready) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_ready = (state_q == IDLE) && rst_n;
  end

  // One restoring-division step plus per-channel result selection.
  // dq_q holds the dividend, which shifts out MSB-first while quotient bits
  // shift in at the LSB. After DW steps it holds the quotient.
  always_comb begin
    in_div  = (state_q == DIV0) || (state_q == DIV1);
    cur     = (state_q == DIV1) ? d1_q : d0_q;
    special = (cur == '0) || (cur == '1);
    bypass  = special || (cf_q <= CFW'(1));
    trial   = {rem_q, dq_q[DW-1]};
    qbit    = (trial >= (RW+1)'(cf_q));
    rem_d   = qbit ? RW'(trial - (RW+1)'(cf_q)) : trial[RW-1:0];
    dq_d    = {dq_q[DW-2:0], qbit};
    ch_done = in_div && (bypass || (cnt_q == CNT_LAST));

    res         = dq_d;
    res_rem_err = |rem_d;
    res_cf_err  = 1'b0;
    if (special || (cf_q == CFW'(1))) begin
      res         = cur;
      res_rem_err = 1'b0;
    end else if (cf_q == '0) begin
      res         = '1;
      res_rem_err = 1'b0;
      res_cf_err  = 1'b1;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d0_q      <= '0;
      d1_q      <= '0;
      cf_q      <= '0;
      dq_q      <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      rem_err_q <= 1'b0;
      cf_err_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      if (accept) begin
        d0_q      <= i_data0;
        d1_q      <= i_data1;
        cf_q      <= i_cf;
        dq_q      <= i_data0;
        rem_q     <= '0;
        cnt_q     <= '0;
        rem_err_q <= 1'b0;
        cf_err_q  <= 1'b0;
      end else if (in_div) begin
        if (ch_done) begin
          // Preload channel 1 so DIV1 starts from a clean divider.
          cnt_q     <= '0;
          rem_q     <= '0;
          dq_q      <= d1_q;
          rem_err_q <= rem_err_q | res_rem_err;
          cf_err_q  <= cf_err_q | res_cf_err;
          if (state_q == DIV0) data0_q <= res;
          else                 data1_q <= res;
        end else begin
          cnt_q <= cnt_q + CW'(1);
          rem_q <= rem_d;
          dq_q  <= dq_d;
        end
      end

      if (state_q == DONE && !valid_q) valid_q <= 1'b1;
      else if (valid_q && i_ready)     valid_q <= 1'b0;
    end
  end

  assign o_valid   = valid_q;
  assign o_data0   = data0_q;
  assign o_data1   = data1_q;
  assign o_rem_err = rem_err_q;
  assign o_cf_err  = cf_err_q;

endmodule

// File: tb/tb_pipe_uncorrect.sv
module tb_pipe_uncorrect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_cf;
  logic [15:0] i_data0, i_data1;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data0, o_data1;
  logic        o_rem_err, o_cf_err;

  int checks = 0;
  int errors = 0;

  pipe_uncorrect #(.DW(16), .CFW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_cf      (i_cf),
    .i_data0   (i_data0),
    .i_data1   (i_data1),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data0   (o_data0),
    .o_data1   (o_data1),
    .o_rem_err (o_rem_err),
    .o_cf_err  (o_cf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Returns the number of edges after the current point until o_valid is seen, or -1.
  task automatic wait_valid(output int lat);
    bit found = 0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (!found) begin
        @(posedge clk); #1;
        if (o_valid) begin
          lat   = k;
          found = 1;
        end
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                              input logic er, input logic ec);
    check({tag, "_d0"},  32'(o_data0),   32'(e0));
    check({tag, "_d1"},  32'(o_data1),   32'(e1));
    check({tag, "_rem"}, 32'(o_rem_err), 32'(er));
    check({tag, "_cf"},  32'(o_cf_err),  32'(ec));
  endtask

  // Accept one transaction, scramble inputs afterwards, and check the result
  // in the cycle o_valid is first seen.
  task automatic run_txn(input string tag, input logic [1:0] cf, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [15:0] e0, input logic [15:0] e1,
                         input logic er, input logic ec, input int elat);
    int lat;
    wait_ready();
    i_cf = cf; i_data0 = d0; i_data1 = d1; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_cf    = ~cf;
    i_data0 = 16'($urandom);
    i_data1 = 16'($urandom);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check_result(tag, e0, e1, er, ec);
  endtask

  task automatic drain(input string tag);
    @(posedge clk); #1;
    check({tag, "_vclr"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_cf = '0; i_data0 = '0; i_data1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check_result("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(o_ready), 32'd1);

    run_txn("div2", 2'd2, 16'h0064, 16'h0007, 16'h0032, 16'h0003, 1'b1, 1'b0, 33);
    drain("div2");
    run_txn("spec", 2'd3, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 3);
    drain("spec");
    run_txn("cf0",  2'd0, 16'h1234, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 3);
    drain("cf0");
    run_txn("div3", 2'd3, 16'h0064, 16'h00FF, 16'h0021, 16'h0055, 1'b1, 1'b0, 33);
    drain("div3");
    run_txn("mix",  2'd2, 16'hFFFF, 16'h0010, 16'hFFFF, 16'h0008, 1'b0, 1'b0, 18);
    drain("mix");

    // Backpressure: results must hold until taken.
    i_ready = 1'b0;
    run_txn("hold", 2'd3, 16'h0096, 16'h0009, 16'h0032, 16'h0003, 1'b0, 1'b0, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_ready", 32'(o_ready), 32'd0);
      check_result("hold_st", 16'h0032, 16'h0003, 1'b0, 1'b0);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_vclr", 32'(o_valid), 32'd0);
    check("hold_rdy", 32'(o_ready), 32'd1);

    // Reset pulse during DIV1 aborts the transaction.
    wait_ready();
    i_cf = 2'd2; i_data0 = 16'h0064; i_data1 = 16'h0007; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 32'(o_ready), 32'd0);
    check("abort_valid", 32'(o_valid), 32'd0);
    check_result("abort", 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("abort_rel", 32'(o_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid) seen = 1;
    end
    check("abort_nov", 32'(seen), 32'd0);
    run_txn("post", 2'd1, 16'h00AB, 16'h0001, 16'h00AB, 16'h0001, 1'b0, 1'b0, 3);
    drain("post");

    // Back-to-back with i_valid held high through DONE.
    wait_ready();
    i_cf = 2'd2; i_data0 = 16'h0064; i_data1 = 16'h0007; i_valid = 1'b1;
    @(posedge clk); #1;
    i_cf = 2'd1; i_data0 = 16'h5555; i_data1 = 16'h0AAA;
    wait_valid(lat);
    check("b2b1_lat", 32'(lat), 32'd33);
    check_result("b2b1", 16'h0032, 16'h0003, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("b2b_vclr", 32'(o_valid), 32'd0);
    check("b2b_idle", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b_acc", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    wait_valid(lat);
    check("b2b2_lat", 32'(lat), 32'd3);
    check_result("b2b2", 16'h5555, 16'h0AAA, 1'b0, 1'b0);
    drain("b2b2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
